ps_inv_seq: RTL

PS_INV_SEQ -- requirements
Module: ps_inv_seq

---
 rtl/ps_inv_seq.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ps_inv_seq.sv
// ps_inv_seq -- sequential inverse ASCON substitution layer.
//
// Purpose:
//   Accepts one 320-bit ASCON state (five 64-bit words x0..x4). It maps each
//   5-bit column {x0[i],x1[i],x2[i],x3[i],x4[i]} through the inverse ASCON
//   S-box. COLS_PER_CYCLE columns are handled per clock, so a result takes
//   64/COLS_PER_CYCLE clocks. The result is held until the consumer takes it.
//
// Parameters:
//   COLS_PER_CYCLE  columns inverted per clock: 1, 2, 4, 8, 16, 32 or 64.
//
// Ports:
//   clock_i      single clock, rising edge
//   resetb_i     synchronous reset, active low
//   in_valid_i   state_i carries a state to invert
//   in_ready_o   block is idle and can accept a state
//   state_i      substituted state, ascon_pack layout (index 0 = x0)
//   out_valid_o  state_o holds a completed result
//   out_ready_i  consumer accepts state_o
//   state_o      inverse-substituted state (the working register)
//   busy_o       transformation in progress
//   err_o        self-check mismatch (constant 0 when the check is absent)
//
// Optional feature:
//   Define PS_INV_SELFCHECK_EN to enable the self-check. The input is kept in
//   a check register. On completion the forward S-box is applied to the
//   result and compared with that copy.

module ps_inv_seq #(
  parameter int COLS_PER_CYCLE = 8
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [4:0][63:0] state_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [4:0][63:0] state_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int GROUPS = 64 / COLS_PER_CYCLE;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  function automatic logic [4:0] inv_sbox(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h14;  5'h01: y = 5'h1A;  5'h02: y = 5'h07;  5'h03: y = 5'h0D;
      5'h04: y = 5'h00;  5'h05: y = 5'h09;  5'h06: y = 5'h0E;  5'h07: y = 5'h12;
      5'h08: y = 5'h0A;  5'h09: y = 5'h06;  5'h0A: y = 5'h1D;  5'h0B: y = 5'h01;
      5'h0C: y = 5'h19;  5'h0D: y = 5'h15;  5'h0E: y = 5'h13;  5'h0F: y = 5'h1E;
      5'h10: y = 5'h18;  5'h11: y = 5'h16;  5'h12: y = 5'h0B;  5'h13: y = 5'h11;
      5'h14: y = 5'h03;  5'h15: y = 5'h05;  5'h16: y = 5'h1C;  5'h17: y = 5'h1F;
      5'h18: y = 5'h17;  5'h19: y = 5'h1B;  5'h1A: y = 5'h04;  5'h1B: y = 5'h08;
      5'h1C: y = 5'h0F;  5'h1D: y = 5'h0C;  5'h1E: y = 5'h10;  default: y = 5'h02;
    endcase
    return y;
  endfunction

  fsm_t             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0][63:0] work_q;
  logic [4:0][63:0] work_d;
  logic             rst_done_q;
  logic             accept;
  logic             last_grp;
  logic [5:0]       col_base;
  logic [5:0]       idx;
  logic [4:0]       col;
  logic [4:0]       sub;

  assign accept   = in_valid_i && in_ready_o;
  assign last_grp = (fsm_q == BUSY) && (cnt_q == LAST_GRP);
  // When COLS_PER_CYCLE is 64 the product truncates to 0. This is the
  // required base, because the counter is always 0 in that case.
  assign col_base = 6'(cnt_q) * 6'(COLS_PER_CYCLE);

  // ---- FSM: state register ----
  always_ff @(posedge clock_i) begin
    if (!resetb_i) fsm_q <= IDLE;
    else           fsm_q <= fsm_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (accept)      fsm_d = BUSY;
      BUSY:    if (last_grp)    fsm_d = DONE;
      DONE:    if (out_ready_i) fsm_d = IDLE;
      default:                  fsm_d = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  // in_ready_o also waits for the first clock after reset is released.
  always_comb begin
    in_ready_o  = (fsm_q == IDLE) && rst_done_q;
    busy_o      = (fsm_q == BUSY);
    out_valid_o = (fsm_q == DONE);
  end

  // ---- Stage: invert the current column group ----
  always_comb begin
    work_d = work_q;
    idx    = '0;
    col    = '0;
    sub    = '0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      idx = col_base + 6'(j);
      col = {work_q[0][idx], work_q[1][idx], work_q[2][idx],
             work_q[3][idx], work_q[4][idx]};
      sub = inv_sbox(col);
      work_d[0][idx] = sub[4];
      work_d[1][idx] = sub[3];
      work_d[2][idx] = sub[2];
      work_d[3][idx] = sub[1];
      work_d[4][idx] = sub[0];
    end
  end

  // ---- Stage: working register and column counter ----
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      cnt_q      <= '0;
      work_q     <= '0;
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      if (accept) begin
        work_q <= state_i;
        cnt_q  <= '0;
      end else if (fsm_q == BUSY) begin
        work_q <= work_d;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign state_o = work_q;

`ifdef PS_INV_SELFCHECK_EN
  function automatic logic [4:0] fwd_sbox(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h04;  5'h01: y = 5'h0B;  5'h02: y = 5'h1F;  5'h03: y = 5'h14;
      5'h04: y = 5'h1A;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
      5'h08: y = 5'h1B;  5'h09: y = 5'h05;  5'h0A: y = 5'h08;  5'h0B: y = 5'h12;
      5'h0C: y = 5'h1D;  5'h0D: y = 5'h03;  5'h0E: y = 5'h06;  5'h0F: y = 5'h1C;
      5'h10: y = 5'h1E;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0E;
      5'h14: y = 5'h00;  5'h15: y = 5'h0D;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
      5'h18: y = 5'h10;  5'h19: y = 5'h0C;  5'h1A: y = 5'h01;  5'h1B: y = 5'h19;
      5'h1C: y = 5'h16;  5'h1D: y = 5'h0A;  5'h1E: y = 5'h0F;  default: y = 5'h17;
    endcase
    return y;
  endfunction

  logic [4:0][63:0] chk_q;
  logic [4:0][63:0] fwd_res;
  logic [4:0]       fcol;
  logic             err_q;

  // Re-apply the forward layer to the final result. work_d is the value the
  // working register takes on the DONE-entry edge.
  always_comb begin
    fwd_res = '0;
    fcol    = '0;
    for (int i = 0; i < 64; i++) begin
      fcol = fwd_sbox({work_d[0][i], work_d[1][i], work_d[2][i],
                       work_d[3][i], work_d[4][i]});
      fwd_res[0][i] = fcol[4];
      fwd_res[1][i] = fcol[3];
      fwd_res[2][i] = fcol[2];
      fwd_res[3][i] = fcol[1];
      fwd_res[4][i] = fcol[0];
    end
  end

  // ---- Stage: check register and error flag ----
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      chk_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept)   chk_q <= state_i;
      if (last_grp) err_q <= (fwd_res != chk_q);
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
